// File: rtl/pila_retorno.sv
// Return-address stack with combinational top-of-stack and sticky overflow/underflow flags.
// Optional macro PILA_CIRCULAR_EN: push while full overwrites the oldest entry instead of being dropped.
module pila_retorno #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            d,
  output logic [AW-1:0]            q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned SPW = $clog2(DEPTH);
  localparam logic [SPW:0] CNT_FULL = (SPW+1)'(DEPTH);

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [SPW:0]   r_count;
  logic           r_ovf;
  logic           r_unf;

  logic [SPW-1:0] w_top_idx;
  logic           w_empty;
  logic           w_full;
  logic           w_wr_en;
  logic [SPW-1:0] w_wr_idx;
  logic [SPW-1:0] w_sp_nxt;
  logic [SPW:0]   w_cnt_nxt;
  logic           w_set_ovf;
  logic           w_set_unf;

  // sp-1 wraps naturally mod DEPTH because DEPTH is a power of two
  assign w_top_idx = r_sp - SPW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);

  assign q         = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp;
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_count;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case ({push, pop})
      2'b11: begin
        if (w_empty) begin
          // the pop half underflows, the push half still lands
          w_set_unf = 1'b1;
          w_wr_en   = 1'b1;
          w_sp_nxt  = r_sp + SPW'(1);
          w_cnt_nxt = r_count + (SPW+1)'(1);
        end else begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_top_idx;
        end
      end
      2'b10: begin
        if (!w_full) begin
          w_wr_en   = 1'b1;
          w_sp_nxt  = r_sp + SPW'(1);
          w_cnt_nxt = r_count + (SPW+1)'(1);
        end else begin
          w_set_ovf = 1'b1;
`ifdef PILA_CIRCULAR_EN
          w_wr_en  = 1'b1;
          w_sp_nxt = r_sp + SPW'(1);
`endif
        end
      end
      2'b01: begin
        if (!w_empty) begin
          w_sp_nxt  = r_sp - SPW'(1);
          w_cnt_nxt = r_count - (SPW+1)'(1);
        end else begin
          w_set_unf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_sp    <= w_sp_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  // storage is deliberately not reset; q masks it while empty
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[w_wr_idx] <= d;
    end
  end

endmodule

// File: doc/pila_retorno.md
# pila_retorno

Hardware return-address stack for the single-cycle CPU. Consumes the `push`/`pop` strobes from the control unit and the return address (PC+1) from the PC datapath. Presents the top-of-stack combinationally so the PC mux, under `s_pila`, can load the return address in the same cycle as a return instruction. Tracks occupancy and records overflow/underflow as sticky error flags.

## Interface
- `AW`, 10: address width; must equal PC width.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `push`  in  1: from the control unit; store `d` on the next edge.
- `pop`  in  1: from the control unit; remove the top entry on the next edge.
- `d`  in  AW: return address to store (PC+1 of the call).
- `q`  out  AW: current top entry, combinational; 0 when empty.
- `count`  out  $clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == DEPTH`.
- `overflow`  out  1: sticky; set by a push while full.
- `underflow`  out  1: sticky; set by a pop while empty.

## Operation
- State:
  - storage array `mem[DEPTH]` of AW bits;
  - pointer `sp` ($clog2(DEPTH) bits) to the next free slot;
  - `count`;
  - two sticky flags.
- `q = empty ? 0 : mem[sp-1]`. The index is taken mod DEPTH.
- Push only, not full: `mem[sp] <= d`, `sp <= sp+1`, `count <= count+1`.
- Pop only, not empty: `sp <= sp-1`, `count <= count-1`. `mem` is unchanged.
- Push and pop together, not empty: replace the top entry.
  - `mem[sp-1] <= d`; `sp` and `count` are unchanged.
  - `q` in that cycle shows the old top, which is the value consumed.
- Push and pop together, empty:
  - The pop is treated as an underflow and `underflow` is set.
  - The push completes normally: `mem[0] <= d`, `count` = 1.
- Pop while empty: `sp` and `count` are unchanged, `q` = 0, `underflow <= 1`.
- Push while full: behaviour depends on configuration (see Configuration); `overflow <= 1` in both modes.
- Sticky flags clear only on `reset`.
- `mem` is not reset. Its contents are unobservable while empty because `q` is forced to 0.

## Timing
- `q`, `empty`, `full` are combinational from registered state. There is zero latency from state to `q`.
- All updates take effect on the rising edge where the strobe is sampled high. A value pushed at edge N is visible on `q` after edge N.
- Reset values, after a `reset` edge:
  - `sp` = 0, `count` = 0;
  - `q` = 0, `empty` = 1, `full` = 0;
  - `overflow` = 0, `underflow` = 0.
- `reset` has priority over `push`/`pop` in the same cycle. The strobes are ignored, with no flag set and no write.
- `push`/`pop` must be stable before the edge. The control unit drives them combinationally from the opcode. There is no handshake or backpressure; a return from an empty stack yields PC = 0.

## Configuration
- Macro: `PILA_CIRCULAR_EN`.
- Defined: push while full overwrites the oldest entry.
  - `mem[sp] <= d`, `sp <= sp+1` (wraps mod DEPTH); `count` stays DEPTH.
  - The newest DEPTH addresses are retained.
- Undefined: push while full is dropped.
  - `mem`, `sp` and `count` are unchanged; the pushed address is lost.
- In both modes, push and pop together while full is the replace case. It is never an overflow.

## Test plan
- Reset, then idle: `q`=0, `count`=0, `empty`=1, `full`=0, both flags 0.
- Push 0x005, 0x00A, 0x0F0 on consecutive edges: `q` reads 0x005, 0x00A, 0x0F0 after each edge.
  - Pop three times: `q` reads 0x00A, 0x005, 0 and `count` goes 2,1,0.
  - No flags set.
- With `count`=2 and top 0x00A, assert push+pop with `d`=0x123:
  - `q`=0x00A before the edge, 0x123 after;
  - `count` stays 2.
- Pop while empty: `underflow`=1 and stays 1 through 5 further valid push/pop cycles. `count` stays 0 on the bad pop.
- Push 0x001..0x011 (17 pushes, DEPTH=16):
  - Without macro: `count`=16, `overflow`=1, `q`=0x010; popping 16 times returns 0x010..0x001.
  - With `PILA_CIRCULAR_EN`: `q`=0x011; popping 16 times returns 0x011..0x002.
- Assert `reset` together with `push`=1, `d`=0x3FF, while `count`=4: after the edge `count`=0, `q`=0, no flags set.
